scalar_issue_ctrl: RTL and testbench

//  Reader side of the scalar FUST: consumes dispatch writes (rd/rs1/rs2/imm, t1/t2 tags).

---
 rtl/scalar_issue_ctrl_if.sv | 40 ++++
 rtl/scalar_issue_ctrl.sv | 177 +++++++++++++++++
 tb/tb_scalar_issue_ctrl.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/scalar_issue_ctrl_if.sv
// Dispatch / writeback / FU handshake bundle for scalar_issue_ctrl.
// The master drives dispatch, writeback and FU status; the slave drives busy and issue.
interface scalar_issue_ctrl_if #(
  parameter int unsigned NFU    = 3,
  parameter int unsigned TAG_W  = 2,
  parameter int unsigned REG_W  = 5,
  parameter int unsigned WORD_W = 32
);
  logic              disp_valid;
  logic [1:0]        disp_fu;
  logic [REG_W-1:0]  disp_rd;
  logic [REG_W-1:0]  disp_rs1;
  logic [REG_W-1:0]  disp_rs2;
  logic [WORD_W-1:0] disp_imm;
  logic [TAG_W-1:0]  disp_t1;
  logic [TAG_W-1:0]  disp_t2;
  logic              wb_valid;
  logic [TAG_W-1:0]  wb_tag;
  logic [NFU-1:0]    fu_ready;
  logic [NFU-1:0]    fu_done;
  logic [NFU-1:0]    fust_busy;
  logic              iss_valid;
  logic [1:0]        iss_fu;
  logic [REG_W-1:0]  iss_rd;
  logic [REG_W-1:0]  iss_rs1;
  logic [REG_W-1:0]  iss_rs2;
  logic [WORD_W-1:0] iss_imm;

  modport master (
    output disp_valid, disp_fu, disp_rd, disp_rs1, disp_rs2, disp_imm, disp_t1, disp_t2,
    output wb_valid, wb_tag, fu_ready, fu_done,
    input  fust_busy, iss_valid, iss_fu, iss_rd, iss_rs1, iss_rs2, iss_imm
  );

  modport slave (
    input  disp_valid, disp_fu, disp_rd, disp_rs1, disp_rs2, disp_imm, disp_t1, disp_t2,
    input  wb_valid, wb_tag, fu_ready, fu_done,
    output fust_busy, iss_valid, iss_fu, iss_rd, iss_rs1, iss_rs2, iss_imm
  );
endinterface

// File: rtl/scalar_issue_ctrl.sv
// Scalar FUST reader: tracks tag readiness per FU entry, issues one ready entry per cycle.
// Define ISSUE_RR_EN for round-robin select; otherwise fixed priority ALU > LD_ST > BRANCH.
module scalar_issue_ctrl #(
  parameter int unsigned NFU    = 3,
  parameter int unsigned TAG_W  = 2,
  parameter int unsigned REG_W  = 5,
  parameter int unsigned WORD_W = 32
) (
  input logic                clk,
  input logic                rst,
  scalar_issue_ctrl_if.slave bus
);

  localparam int unsigned FuW = 2;

  typedef enum logic [1:0] {FustEmpty, FustWait, FustRdy, FustEx} fust_state_e;

  fust_state_e       r_state     [NFU];
  fust_state_e       w_state_nxt [NFU];
  logic [REG_W-1:0]  r_rd        [NFU];
  logic [REG_W-1:0]  r_rs1       [NFU];
  logic [REG_W-1:0]  r_rs2       [NFU];
  logic [WORD_W-1:0] r_imm       [NFU];
  logic [TAG_W-1:0]  r_t1        [NFU];
  logic [TAG_W-1:0]  r_t2        [NFU];

  logic              r_iss_valid;
  logic [FuW-1:0]    r_iss_fu;
  logic [REG_W-1:0]  r_iss_rd;
  logic [REG_W-1:0]  r_iss_rs1;
  logic [REG_W-1:0]  r_iss_rs2;
  logic [WORD_W-1:0] r_iss_imm;

  logic [TAG_W-1:0]  w_disp_t1;
  logic [TAG_W-1:0]  w_disp_t2;
  logic [NFU-1:0]    w_disp_acc;
  logic [NFU-1:0]    w_can_iss;
  logic [NFU-1:0]    w_busy;
  logic              w_sel_valid;
  logic [FuW-1:0]    w_sel_idx;

  // Same-cycle writeback bypass on the incoming tags.
  always_comb begin
    w_disp_t1 = (bus.wb_valid && (bus.disp_t1 == bus.wb_tag)) ? '0 : bus.disp_t1;
    w_disp_t2 = (bus.wb_valid && (bus.disp_t2 == bus.wb_tag)) ? '0 : bus.disp_t2;
  end

  always_comb begin
    w_disp_acc = '0;
    w_can_iss  = '0;
    w_busy     = '0;
    for (int i = 0; i < NFU; i++) begin
      w_disp_acc[i] = bus.disp_valid && (bus.disp_fu == FuW'(i)) && (r_state[i] == FustEmpty);
      w_can_iss[i]  = (r_state[i] == FustRdy) && bus.fu_ready[i];
      w_busy[i]     = (r_state[i] != FustEmpty);
    end
  end

`ifdef ISSUE_RR_EN
  logic [FuW-1:0] r_ptr;

  always_comb begin
    int unsigned idx;
    idx         = 0;
    w_sel_valid = 1'b0;
    w_sel_idx   = '0;
    for (int unsigned k = 0; k < NFU; k++) begin
      idx = (32'(r_ptr) + k) % NFU;
      if (!w_sel_valid && w_can_iss[idx]) begin
        w_sel_valid = 1'b1;
        w_sel_idx   = FuW'(idx);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr <= '0;
    end else if (w_sel_valid) begin
      r_ptr <= (32'(w_sel_idx) == NFU - 1) ? '0 : w_sel_idx + 1'b1;
    end
  end
`else
  always_comb begin
    w_sel_valid = 1'b0;
    w_sel_idx   = '0;
    for (int k = 0; k < NFU; k++) begin
      if (!w_sel_valid && w_can_iss[k]) begin
        w_sel_valid = 1'b1;
        w_sel_idx   = FuW'(k);
      end
    end
  end
`endif

  // WAIT only sees registered tags, so RDY lands one edge after the writeback clears them.
  always_comb begin
    for (int i = 0; i < NFU; i++) begin
      w_state_nxt[i] = r_state[i];
      unique case (r_state[i])
        FustEmpty: begin
          if (w_disp_acc[i]) begin
            w_state_nxt[i] = ((w_disp_t1 == '0) && (w_disp_t2 == '0)) ? FustRdy : FustWait;
          end
        end
        FustWait: begin
          if ((r_t1[i] == '0) && (r_t2[i] == '0)) w_state_nxt[i] = FustRdy;
        end
        FustRdy: begin
          if (w_sel_valid && (w_sel_idx == FuW'(i))) w_state_nxt[i] = FustEx;
        end
        FustEx: begin
          if (bus.fu_done[i]) w_state_nxt[i] = FustEmpty;
        end
        default: w_state_nxt[i] = FustEmpty;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NFU; i++) begin
        r_state[i] <= FustEmpty;
        r_rd[i]    <= '0;
        r_rs1[i]   <= '0;
        r_rs2[i]   <= '0;
        r_imm[i]   <= '0;
        r_t1[i]    <= '0;
        r_t2[i]    <= '0;
      end
    end else begin
      for (int i = 0; i < NFU; i++) begin
        r_state[i] <= w_state_nxt[i];
        if (w_disp_acc[i]) begin
          r_rd[i]  <= bus.disp_rd;
          r_rs1[i] <= bus.disp_rs1;
          r_rs2[i] <= bus.disp_rs2;
          r_imm[i] <= bus.disp_imm;
          r_t1[i]  <= w_disp_t1;
          r_t2[i]  <= w_disp_t2;
        end else if ((r_state[i] == FustWait) && bus.wb_valid) begin
          if (r_t1[i] == bus.wb_tag) r_t1[i] <= '0;
          if (r_t2[i] == bus.wb_tag) r_t2[i] <= '0;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_iss_valid <= 1'b0;
      r_iss_fu    <= '0;
      r_iss_rd    <= '0;
      r_iss_rs1   <= '0;
      r_iss_rs2   <= '0;
      r_iss_imm   <= '0;
    end else begin
      r_iss_valid <= w_sel_valid;
      if (w_sel_valid) begin
        r_iss_fu  <= w_sel_idx;
        r_iss_rd  <= r_rd[w_sel_idx];
        r_iss_rs1 <= r_rs1[w_sel_idx];
        r_iss_rs2 <= r_rs2[w_sel_idx];
        r_iss_imm <= r_imm[w_sel_idx];
      end
    end
  end

  assign bus.fust_busy = w_busy;
  assign bus.iss_valid = r_iss_valid;
  assign bus.iss_fu    = r_iss_fu;
  assign bus.iss_rd    = r_iss_rd;
  assign bus.iss_rs1   = r_iss_rs1;
  assign bus.iss_rs2   = r_iss_rs2;
  assign bus.iss_imm   = r_iss_imm;

endmodule

// File: tb/tb_scalar_issue_ctrl.sv
// Directed table-driven bench for scalar_issue_ctrl, plus a mid-run reset sequence.
module tb_scalar_issue_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  scalar_issue_ctrl_if #(.NFU(3), .TAG_W(2), .REG_W(5), .WORD_W(32)) bus ();

  scalar_issue_ctrl #(.NFU(3), .TAG_W(2), .REG_W(5), .WORD_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic       dv;
    logic [1:0] fu;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [1:0] t1;
    logic [1:0] t2;
    logic       wbv;
    logic [1:0] wbt;
    logic [2:0] rdy;
    logic [2:0] done;
    logic [2:0] ebusy;
    logic       eiv;
    logic [1:0] efu;
    logic [4:0] erd;
    logic [4:0] ers1;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic dv, input logic [1:0] fu, input logic [4:0] rd,
                              input logic [4:0] rs1, input logic [1:0] t1, input logic [1:0] t2,
                              input logic wbv, input logic [1:0] wbt, input logic [2:0] rdy,
                              input logic [2:0] done, input logic [2:0] ebusy, input logic eiv,
                              input logic [1:0] efu, input logic [4:0] erd,
                              input logic [4:0] ers1);
    vec_t v;
    v.dv = dv; v.fu = fu; v.rd = rd; v.rs1 = rs1; v.t1 = t1; v.t2 = t2;
    v.wbv = wbv; v.wbt = wbt; v.rdy = rdy; v.done = done;
    v.ebusy = ebusy; v.eiv = eiv; v.efu = efu; v.erd = erd; v.ers1 = ers1;
    return v;
  endfunction

  // Immediate and rs2 are derived from rd/rs1 so a single expected rd/rs1 pins all fields.
  function automatic logic [31:0] imm_of(input logic [4:0] rd, input logic [4:0] rs1);
    return 32'hA500_0000 | (32'(rd) << 8) | 32'(rs1);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic dv, input logic [1:0] fu, input logic [4:0] rd,
                       input logic [4:0] rs1, input logic [1:0] t1, input logic [1:0] t2,
                       input logic wbv, input logic [1:0] wbt, input logic [2:0] rdy,
                       input logic [2:0] done);
    bus.disp_valid = dv;
    bus.disp_fu    = fu;
    bus.disp_rd    = rd;
    bus.disp_rs1   = rs1;
    bus.disp_rs2   = rs1 + 5'd1;
    bus.disp_imm   = imm_of(rd, rs1);
    bus.disp_t1    = t1;
    bus.disp_t2    = t2;
    bus.wb_valid   = wbv;
    bus.wb_tag     = wbt;
    bus.fu_ready   = rdy;
    bus.fu_done    = done;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_busy"}, 32'(bus.fust_busy), 32'h0);
    check({tag, "_iss_valid"}, 32'(bus.iss_valid), 32'h0);
    check({tag, "_iss_rd"}, 32'(bus.iss_rd), 32'h0);
    check({tag, "_iss_imm"}, bus.iss_imm, 32'h0);
  endtask

  initial begin
    logic [1:0] fa, fb;
    logic [4:0] ra, rb, sa, sb;
`ifdef ISSUE_RR_EN
    fa = 2'd1; ra = 5'd12; sa = 5'd13; fb = 2'd0; rb = 5'd10; sb = 5'd11;
`else
    fa = 2'd0; ra = 5'd10; sa = 5'd11; fb = 2'd1; rb = 5'd12; sb = 5'd13;
`endif
    //       dv fu  rd   rs1 t1 t2 wbv wbt rdy   done    busy   iv fu  rd   rs1
    // LD_ST waits on ALU tag; writeback clears it, RDY next edge, issue the edge after.
    vecs.push_back(mk(1, 1, 7,  3,  1, 0, 0, 0, 3'b111, 3'b000, 3'b010, 0, 0, 0,  0));
    vecs.push_back(mk(0, 0, 0,  0,  0, 0, 0, 0, 3'b111, 3'b000, 3'b010, 0, 0, 0,  0));
    vecs.push_back(mk(0, 0, 0,  0,  0, 0, 1, 1, 3'b111, 3'b000, 3'b010, 0, 0, 0,  0));
    vecs.push_back(mk(0, 0, 0,  0,  0, 0, 0, 0, 3'b111, 3'b000, 3'b010, 0, 0, 0,  0));
    vecs.push_back(mk(0, 0, 0,  0,  0, 0, 0, 0, 3'b111, 3'b000, 3'b010, 1, 1, 7,  3));
    vecs.push_back(mk(0, 0, 0,  0,  0, 0, 0, 0, 3'b111, 3'b010, 3'b000, 0, 1, 7,  3));
    // BRANCH with t2 bypassed by a same-cycle writeback.
    vecs.push_back(mk(1, 2, 9,  6,  0, 2, 1, 2, 3'b111, 3'b000, 3'b100, 0, 1, 7,  3));
    vecs.push_back(mk(0, 0, 0,  0,  0, 0, 0, 0, 3'b111, 3'b000, 3'b100, 1, 2, 9,  6));
    vecs.push_back(mk(0, 0, 0,  0,  0, 0, 0, 0, 3'b111, 3'b100, 3'b000, 0, 2, 9,  6));
    // Plain ALU op; busy holds until fu_done.
    vecs.push_back(mk(1, 0, 5,  1,  0, 0, 0, 0, 3'b111, 3'b000, 3'b001, 0, 2, 9,  6));
    vecs.push_back(mk(0, 0, 0,  0,  0, 0, 0, 0, 3'b111, 3'b000, 3'b001, 1, 0, 5,  1));
    vecs.push_back(mk(0, 0, 0,  0,  0, 0, 0, 0, 3'b111, 3'b000, 3'b001, 0, 0, 5,  1));
    vecs.push_back(mk(0, 0, 0,  0,  0, 0, 0, 0, 3'b111, 3'b001, 3'b000, 0, 0, 5,  1));
    // ALU and LD_ST both RDY with FUs stalled; fu_done on a RDY entry is ignored.
    vecs.push_back(mk(1, 0, 10, 11, 0, 0, 0, 0, 3'b000, 3'b000, 3'b001, 0, 0, 5,  1));
    vecs.push_back(mk(1, 1, 12, 13, 0, 0, 0, 0, 3'b000, 3'b001, 3'b011, 0, 0, 5,  1));
    vecs.push_back(mk(0, 0, 0,  0,  0, 0, 0, 0, 3'b011, 3'b000, 3'b011, 1, fa, ra, sa));
    vecs.push_back(mk(0, 0, 0,  0,  0, 0, 0, 0, 3'b011, 3'b000, 3'b011, 1, fb, rb, sb));
    vecs.push_back(mk(0, 0, 0,  0,  0, 0, 0, 0, 3'b111, 3'b011, 3'b000, 0, fb, rb, sb));
    // Dispatch to a busy entry, alone and coinciding with fu_done, is dropped; FU_NONE ignored.
    vecs.push_back(mk(1, 0, 20, 21, 0, 0, 0, 0, 3'b111, 3'b000, 3'b001, 0, fb, rb, sb));
    vecs.push_back(mk(0, 0, 0,  0,  0, 0, 0, 0, 3'b111, 3'b000, 3'b001, 1, 0, 20, 21));
    vecs.push_back(mk(1, 0, 30, 31, 0, 0, 0, 0, 3'b111, 3'b000, 3'b001, 0, 0, 20, 21));
    vecs.push_back(mk(1, 0, 25, 26, 0, 0, 0, 0, 3'b111, 3'b001, 3'b000, 0, 0, 20, 21));
    vecs.push_back(mk(0, 0, 0,  0,  0, 0, 0, 0, 3'b111, 3'b000, 3'b000, 0, 0, 20, 21));
    vecs.push_back(mk(1, 3, 22, 23, 0, 0, 0, 0, 3'b111, 3'b000, 3'b000, 0, 0, 20, 21));
    vecs.push_back(mk(0, 0, 0,  0,  0, 0, 0, 0, 3'b111, 3'b000, 3'b000, 0, 0, 20, 21));

    drive(0, 0, 0, 0, 0, 0, 0, 0, 3'b111, 3'b000);
    repeat (2) @(posedge clk);
    #1;
    check_idle("reset");
    rst = 1'b0;

    foreach (vecs[k]) begin
      drive(vecs[k].dv, vecs[k].fu, vecs[k].rd, vecs[k].rs1, vecs[k].t1, vecs[k].t2,
            vecs[k].wbv, vecs[k].wbt, vecs[k].rdy, vecs[k].done);
      @(posedge clk);
      #1;
      check($sformatf("v%0d_busy", k), 32'(bus.fust_busy), 32'(vecs[k].ebusy));
      check($sformatf("v%0d_iss_valid", k), 32'(bus.iss_valid), 32'(vecs[k].eiv));
      check($sformatf("v%0d_iss_fu", k), 32'(bus.iss_fu), 32'(vecs[k].efu));
      check($sformatf("v%0d_iss_rd", k), 32'(bus.iss_rd), 32'(vecs[k].erd));
      check($sformatf("v%0d_iss_rs1", k), 32'(bus.iss_rs1), 32'(vecs[k].ers1));
      if (vecs[k].erd != 5'd0) begin
        check($sformatf("v%0d_iss_rs2", k), 32'(bus.iss_rs2), 32'(vecs[k].ers1 + 5'd1));
        check($sformatf("v%0d_iss_imm", k), bus.iss_imm, imm_of(vecs[k].erd, vecs[k].ers1));
      end
    end

    // Reset asserted mid-cycle right after an issue clears everything immediately.
    drive(1, 0, 15, 14, 0, 0, 0, 0, 3'b111, 3'b000);
    @(posedge clk);
    #1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 3'b111, 3'b000);
    @(posedge clk);
    #1;
    check("pre_rst_iss_valid", 32'(bus.iss_valid), 32'h1);
    check("pre_rst_iss_rd", 32'(bus.iss_rd), 32'd15);
    #2;
    rst = 1'b1;
    #1;
    check_idle("async_rst");
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_idle("post_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
